// File: rtl/types_pkg.sv
// Shared types for the shot sequencer and the strategy multiplexer it drives.
//   variants_t    : strategy index (3 bits; values >= NUM_VARIANTS are illegal)
//   parameters_t  : timing parameters handed to the selected strategy
//   seq_state_t   : sequencer state reported on state_o
//   seq_err_t     : sticky error code reported on err_o
//   par_valid()   : true when every mandatory timing field is non-zero
package types_pkg;

    localparam int NUM_VARIANTS = 5;

    typedef logic [2:0] variants_t;

    typedef struct packed {
        logic [31:0] TRIGGER_LEN;
        logic [31:0] DETONATE_LEN;
        logic [31:0] DETECTOR_READY_TIMEOUT;
    } parameters_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        FIRE     = 3'd2,
        RUN      = 3'd3,
        COOLDOWN = 3'd4,
        FAULT    = 3'd5
    } seq_state_t;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_BAD_STRATEGY = 3'd1,
        ERR_BAD_PARAM    = 3'd2,
        ERR_TIMEOUT      = 3'd3,
        ERR_SPURIOUS     = 3'd4
    } seq_err_t;

    function automatic logic par_valid(input parameters_t p);
        return (p.TRIGGER_LEN != '0) && (p.DETONATE_LEN != '0) &&
               (p.DETECTOR_READY_TIMEOUT != '0);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the start pulse, run watchdog and cooldown.
//   clock, reset : system clock, asynchronous active-low reset
//   load         : load load_val this cycle (takes priority over en)
//   load_val     : value loaded; the counter then reports zero load_val cycles later
//   en           : count down by one per cycle, holding at zero
//   zero         : count is zero
module seq_timer #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/shot_sequencer.sv
// Shot sequencer: arms a strategy, fires a fixed-length start pulse into the
// strategy mux, watches for completion with a watchdog, enforces a re-arm
// cooldown and latches faults until the operator aborts.
//   clock, reset                    : system clock, asynchronous active-low reset
//   cmd_arm, cmd_fire, cmd_abort    : single-cycle operator commands
//   strategy_req, par_req           : requested strategy / timing parameters
//   strategy_sel, par               : values latched on a valid arm
//   start                           : start pulse (gated off by cmd_abort at once)
//   detonator_triggered,
//   output_trigger                  : status from the strategy mux (same clock)
//   state_o, err_o, shot_count      : state, sticky error, completed shots
module shot_sequencer
    import types_pkg::*;
#(
    parameter int START_LEN    = 20,
    parameter int RUN_TIMEOUT  = 10_000_000,
    parameter int COOLDOWN_LEN = 200_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_arm,
    input  logic        cmd_fire,
    input  logic        cmd_abort,
    input  variants_t   strategy_req,
    input  parameters_t par_req,
    output variants_t   strategy_sel,
    output parameters_t par,
    output logic        start,
    input  logic        detonator_triggered,
    input  logic        output_trigger,
    output seq_state_t  state_o,
    output seq_err_t    err_o,
    output logic [15:0] shot_count
);

    // The timer reports zero load_val cycles after the load, so loading N-1
    // makes a phase last exactly N cycles.
    localparam logic [31:0] START_LOAD = 32'(START_LEN - 1);
    localparam logic [31:0] RUN_LOAD   = 32'(RUN_TIMEOUT - 1);
    localparam logic [31:0] COOL_LOAD  = 32'(COOLDOWN_LEN - 1);
    localparam variants_t   NUM_VAR_V  = variants_t'(NUM_VARIANTS);

    seq_state_t  state_q, state_d;
    seq_err_t    err_q, err_d;
    logic        start_q, start_d;
    logic [15:0] count_q, count_d;
    variants_t   sel_q, sel_d;
    parameters_t par_q, par_d;
    logic        otrig_q, det_q;

    logic        tmr_load;
    logic [31:0] tmr_val;
    logic        tmr_en;
    logic        tmr_zero;

    // Both status inputs come from this clock domain: one delay register is
    // enough for edge detection.
    logic trig_fall, det_rise;
    assign trig_fall = otrig_q & ~output_trigger;
    assign det_rise  = detonator_triggered & ~det_q;

    assign tmr_en = (state_q == FIRE) || (state_q == RUN) || (state_q == COOLDOWN);

    seq_timer #(.W(32)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        start_d  = start_q;
        count_d  = count_q;
        sel_d    = sel_q;
        par_d    = par_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (det_rise) begin
                    state_d = FAULT;
                    err_d   = ERR_SPURIOUS;
                end else if (cmd_arm) begin
                    if (strategy_req >= NUM_VAR_V) begin
                        state_d = FAULT;
                        err_d   = ERR_BAD_STRATEGY;
                    end else if (!par_valid(par_req)) begin
                        state_d = FAULT;
                        err_d   = ERR_BAD_PARAM;
                    end else begin
                        sel_d   = strategy_req;
                        par_d   = par_req;
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (cmd_abort) begin
                    state_d = IDLE;
                end else if (det_rise) begin
                    state_d = FAULT;
                    err_d   = ERR_SPURIOUS;
                end else if (cmd_fire) begin
                    state_d  = FIRE;
                    start_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = START_LOAD;
                end
            end
            FIRE: begin
                if (cmd_abort) begin
                    state_d = IDLE;
                    start_d = 1'b0;
                end else if (tmr_zero) begin
                    state_d  = RUN;
                    start_d  = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = RUN_LOAD;
                end
            end
            RUN: begin
                // Completion wins over a watchdog expiry in the same cycle.
                if (cmd_abort) begin
                    state_d = IDLE;
                end else if (trig_fall) begin
                    count_d  = count_q + 16'd1;
                    state_d  = COOLDOWN;
                    tmr_load = 1'b1;
                    tmr_val  = COOL_LOAD;
                end else if (tmr_zero) begin
                    state_d = FAULT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            COOLDOWN: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (cmd_abort) begin
                    state_d = IDLE;
                    err_d   = ERR_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            err_q   <= ERR_NONE;
            start_q <= 1'b0;
            count_q <= '0;
            sel_q   <= '0;
            par_q   <= '0;
            otrig_q <= 1'b0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            start_q <= start_d;
            count_q <= count_d;
            sel_q   <= sel_d;
            par_q   <= par_d;
            otrig_q <= output_trigger;
            det_q   <= detonator_triggered;
        end
    end

    // Abort removes the pulse in the same cycle, before the state register reacts.
    assign start        = start_q & ~cmd_abort;
    assign state_o      = state_q;
    assign err_o        = err_q;
    assign shot_count   = count_q;
    assign strategy_sel = sel_q;
    assign par          = par_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Testbench for shot_sequencer: reset values, a table of command vectors,
// hand-written multi-cycle sequences and a randomized run checked against an
// elapsed-time reference model.
module tb_shot_sequencer;
    import types_pkg::*;

    localparam int T_START = 20;
    localparam int T_RUN   = 1000;
    localparam int T_COOL  = 200;

    logic        clock;
    logic        reset;
    logic        cmd_arm, cmd_fire, cmd_abort;
    variants_t   strategy_req;
    parameters_t par_req;
    variants_t   strategy_sel;
    parameters_t par;
    logic        start;
    logic        detonator_triggered, output_trigger;
    seq_state_t  state_o;
    seq_err_t    err_o;
    logic [15:0] shot_count;

    int n_tests = 0;
    int n_fail  = 0;

    shot_sequencer #(
        .START_LEN    (T_START),
        .RUN_TIMEOUT  (T_RUN),
        .COOLDOWN_LEN (T_COOL)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .cmd_arm             (cmd_arm),
        .cmd_fire            (cmd_fire),
        .cmd_abort           (cmd_abort),
        .strategy_req        (strategy_req),
        .par_req             (par_req),
        .strategy_sel        (strategy_sel),
        .par                 (par),
        .start               (start),
        .detonator_triggered (detonator_triggered),
        .output_trigger      (output_trigger),
        .state_o             (state_o),
        .err_o               (err_o),
        .shot_count          (shot_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        cmd_arm   = 1'b0;
        cmd_fire  = 1'b0;
        cmd_abort = 1'b0;
    endtask

    function automatic parameters_t rand_par(input logic bad);
        parameters_t p;
        p.TRIGGER_LEN            = $urandom_range(1, 5000);
        p.DETONATE_LEN           = $urandom_range(1, 5000);
        p.DETECTOR_READY_TIMEOUT = $urandom_range(1, 5000);
        if (bad) begin
            case ($urandom % 3)
                0:       p.TRIGGER_LEN = '0;
                1:       p.DETONATE_LEN = '0;
                default: p.DETECTOR_READY_TIMEOUT = '0;
            endcase
        end
        return p;
    endfunction

    typedef struct {
        logic       arm, fire, abort, det, bad_par;
        logic [2:0] strat;
        seq_state_t exp_state;
        seq_err_t   exp_err;
        logic       exp_start;
        logic [2:0] exp_sel;
    } vec_t;

    function automatic vec_t mk(input logic arm, input logic fire, input logic abort,
                                input logic det, input logic bad_par, input logic [2:0] strat,
                                input seq_state_t st, input seq_err_t er, input logic stt,
                                input logic [2:0] sel);
        vec_t v;
        v.arm = arm; v.fire = fire; v.abort = abort; v.det = det; v.bad_par = bad_par;
        v.strat = strat; v.exp_state = st; v.exp_err = er; v.exp_start = stt; v.exp_sel = sel;
        return v;
    endfunction

    // Enter RUN via arm+fire; returns with the bench in the first RUN cycle.
    task automatic arm_fire_to_run(input logic [2:0] s);
        int n;
        cmd_arm = 1'b1; strategy_req = s; par_req = rand_par(1'b0); cyc(); clr();
        cmd_fire = 1'b1; cyc(); clr();
        n = 0;
        while (state_o != RUN && n < 100) begin n++; cyc(); end
        chk("reach_run", state_o, RUN);
    endtask

    task automatic wait_cooldown_done();
        int n;
        n = 0;
        while (state_o == COOLDOWN && n < 5000) begin n++; cyc(); end
        chk("cooldown_exit", state_o, IDLE);
    endtask

    task automatic do_shot(input logic [2:0] s, input int d, input logic [15:0] cnt_before);
        parameters_t p;
        int n;
        p = rand_par(1'b0);
        cmd_arm = 1'b1; strategy_req = s; par_req = p; cyc(); clr();
        chk("shot_armed", state_o, ARMED);
        chk("shot_sel", strategy_sel, s);
        chk("shot_par", par, p);
        par_req = rand_par(1'b0);
        strategy_req = 3'(s + 3'd1);
        cmd_fire = 1'b1; cyc(); clr();
        n = 0;
        while (start && n < 100) begin n++; cyc(); end
        chk("start_len", n, T_START);
        chk("run_entry", state_o, RUN);
        detonator_triggered = 1'b1;
        output_trigger = 1'b1;
        repeat (d) cyc();
        chk("run_par", par, p);
        chk("run_sel", strategy_sel, s);
        output_trigger = 1'b0; cyc();
        chk("cool_entry", state_o, COOLDOWN);
        chk("count_inc", shot_count, 16'(cnt_before + 16'd1));
        detonator_triggered = 1'b0;
        n = 0;
        while (state_o == COOLDOWN && n < 5000) begin
            n++;
            if (n == 3) begin cmd_arm = 1'b1; cmd_fire = 1'b1; strategy_req = 3'd0; end
            cyc(); clr();
        end
        chk("cool_len", n, T_COOL);
        chk("cool_exit", state_o, IDLE);
        chk("cool_sel_kept", strategy_sel, s);
        chk("cool_par_kept", par, p);
    endtask

    // Reference model state: phase plus cycles spent in it (1 = first cycle).
    seq_state_t  m_st;
    int          m_el;
    seq_err_t    m_err;
    logic [15:0] m_cnt;
    variants_t   m_sel;
    parameters_t m_par;
    logic        m_op, m_dp;

    vec_t        tbl[18];
    parameters_t good_par, bad_par;

    initial begin
        logic a, f, ab, fall, drise;
        seq_state_t n_st;

        reset = 1'b0; clr();
        strategy_req = '0; par_req = '0;
        detonator_triggered = 1'b0; output_trigger = 1'b0;
        good_par = rand_par(1'b0);
        bad_par = good_par; bad_par.DETONATE_LEN = '0;

        // Commands while reset is low must not disturb the reset values.
        cmd_arm = 1'b1; cmd_fire = 1'b1; strategy_req = 3'd3; par_req = good_par;
        repeat (3) cyc();
        chk("rst_state", state_o, IDLE);
        chk("rst_start", start, 1'b0);
        chk("rst_err", err_o, ERR_NONE);
        chk("rst_count", shot_count, 16'd0);
        chk("rst_sel", strategy_sel, 3'd0);
        chk("rst_par", par, '0);
        clr(); reset = 1'b1; cyc();
        chk("rst_release", state_o, IDLE);

        //         arm fire abt det bad strat  state     err               start sel
        tbl[0]  = mk(1, 0, 0, 0, 0, 3'd7, FAULT, ERR_BAD_STRATEGY, 0, 3'd0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 3'd0, FAULT, ERR_BAD_STRATEGY, 0, 3'd0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 3'd1, FAULT, ERR_BAD_STRATEGY, 0, 3'd0);
        tbl[3]  = mk(0, 0, 1, 0, 0, 3'd0, IDLE,  ERR_NONE,         0, 3'd0);
        tbl[4]  = mk(1, 0, 0, 0, 1, 3'd1, FAULT, ERR_BAD_PARAM,    0, 3'd0);
        tbl[5]  = mk(0, 0, 1, 0, 0, 3'd0, IDLE,  ERR_NONE,         0, 3'd0);
        tbl[6]  = mk(0, 1, 0, 0, 0, 3'd0, IDLE,  ERR_NONE,         0, 3'd0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 3'd0, IDLE,  ERR_NONE,         0, 3'd0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 3'd3, ARMED, ERR_NONE,         0, 3'd3);
        tbl[9]  = mk(1, 0, 0, 0, 0, 3'd4, ARMED, ERR_NONE,         0, 3'd3);
        tbl[10] = mk(0, 0, 0, 1, 0, 3'd0, FAULT, ERR_SPURIOUS,     0, 3'd3);
        tbl[11] = mk(0, 0, 1, 0, 0, 3'd0, IDLE,  ERR_NONE,         0, 3'd3);
        tbl[12] = mk(1, 0, 0, 0, 0, 3'd2, ARMED, ERR_NONE,         0, 3'd2);
        tbl[13] = mk(1, 1, 0, 0, 0, 3'd4, FIRE,  ERR_NONE,         1, 3'd2);
        tbl[14] = mk(0, 0, 0, 0, 0, 3'd0, FIRE,  ERR_NONE,         1, 3'd2);
        tbl[15] = mk(0, 1, 1, 0, 0, 3'd0, IDLE,  ERR_NONE,         0, 3'd2);
        tbl[16] = mk(0, 0, 0, 1, 0, 3'd0, FAULT, ERR_SPURIOUS,     0, 3'd2);
        tbl[17] = mk(0, 0, 1, 0, 0, 3'd0, IDLE,  ERR_NONE,         0, 3'd2);

        for (int i = 0; i < 18; i++) begin
            cmd_arm = tbl[i].arm; cmd_fire = tbl[i].fire; cmd_abort = tbl[i].abort;
            detonator_triggered = tbl[i].det;
            strategy_req = tbl[i].strat;
            par_req = tbl[i].bad_par ? bad_par : good_par;
            cyc(); clr(); detonator_triggered = 1'b0; #1;
            chk($sformatf("tbl%0d_state", i), state_o, tbl[i].exp_state);
            chk($sformatf("tbl%0d_err", i), err_o, tbl[i].exp_err);
            chk($sformatf("tbl%0d_start", i), start, tbl[i].exp_start);
            chk($sformatf("tbl%0d_sel", i), strategy_sel, tbl[i].exp_sel);
        end
        chk("tbl_count", shot_count, 16'd0);

        // Full shots over every strategy; strategy 2 uses the long (scaled 400 us) run.
        for (int s = 0; s < NUM_VARIANTS; s++) begin
            do_shot(3'(s), (s == 2) ? 400 : 30 + 10 * s, 16'(s));
        end
        chk("five_shots", shot_count, 16'd5);

        // Watchdog expiry with no completion edge.
        begin
            int n;
            arm_fire_to_run(3'd1);
            n = 0;
            while (state_o == RUN && n < 5000) begin n++; cyc(); end
            chk("timeout_len", n, T_RUN);
            chk("timeout_state", state_o, FAULT);
            chk("timeout_err", err_o, ERR_TIMEOUT);
            chk("timeout_count", shot_count, 16'd5);
            cmd_abort = 1'b1; cyc(); clr();
            chk("timeout_abort_state", state_o, IDLE);
            chk("timeout_abort_err", err_o, ERR_NONE);
        end

        // Completion edge on the very last watchdog cycle counts as completion.
        arm_fire_to_run(3'd4);
        output_trigger = 1'b1; cyc();
        repeat (T_RUN - 2) cyc();
        chk("edge_last_state", state_o, RUN);
        output_trigger = 1'b0; cyc();
        chk("edge_vs_timeout_state", state_o, COOLDOWN);
        chk("edge_vs_timeout_err", err_o, ERR_NONE);
        chk("edge_vs_timeout_count", shot_count, 16'd6);
        wait_cooldown_done();

        // Abort on the fifth FIRE cycle.
        cmd_arm = 1'b1; strategy_req = 3'd0; par_req = good_par; cyc(); clr();
        cmd_fire = 1'b1; cyc(); clr();
        repeat (4) cyc();
        chk("fire5_state", state_o, FIRE);
        chk("fire5_start_high", start, 1'b1);
        cmd_abort = 1'b1; #1;
        chk("abort_start_comb", start, 1'b0);
        cyc(); clr();
        chk("abort_state", state_o, IDLE);
        chk("abort_start", start, 1'b0);
        chk("abort_count", shot_count, 16'd6);

        // Asynchronous reset in the middle of the start pulse.
        cmd_arm = 1'b1; strategy_req = 3'd3; par_req = good_par; cyc(); clr();
        cmd_fire = 1'b1; cyc(); clr();
        repeat (2) cyc();
        chk("pre_reset_start", start, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_start", start, 1'b0);
        chk("async_reset_state", state_o, IDLE);
        chk("async_reset_count", shot_count, 16'd0);
        @(posedge clock); #1;
        reset = 1'b1; cyc();
        chk("post_reset_state", state_o, IDLE);

        // Randomized run against the elapsed-time model.
        m_st = IDLE; m_el = 1; m_err = ERR_NONE; m_cnt = '0; m_sel = '0; m_par = '0;
        m_op = output_trigger; m_dp = detonator_triggered;
        for (int c = 0; c < 15000; c++) begin
            a  = ($urandom % 16) == 0;
            f  = ($urandom % 16) == 0;
            ab = ($urandom % 150) == 0;
            cmd_arm = a; cmd_fire = f; cmd_abort = ab;
            strategy_req = 3'($urandom % 8);
            par_req = rand_par(($urandom % 8) == 0);
            detonator_triggered = ($urandom % 250) == 0;
            if (($urandom % 60) == 0) output_trigger = ~output_trigger;
            #1;
            chk("rnd_start", start, (m_st == FIRE) && !ab);

            fall  = m_op && !output_trigger;
            drise = detonator_triggered && !m_dp;
            n_st  = m_st;
            case (m_st)
                IDLE: begin
                    if (drise) begin n_st = FAULT; m_err = ERR_SPURIOUS; end
                    else if (a) begin
                        if (int'(strategy_req) >= NUM_VARIANTS) begin
                            n_st = FAULT; m_err = ERR_BAD_STRATEGY;
                        end else if (par_req.TRIGGER_LEN == 0 || par_req.DETONATE_LEN == 0 ||
                                     par_req.DETECTOR_READY_TIMEOUT == 0) begin
                            n_st = FAULT; m_err = ERR_BAD_PARAM;
                        end else begin
                            n_st = ARMED; m_sel = strategy_req; m_par = par_req;
                        end
                    end
                end
                ARMED: begin
                    if (ab) n_st = IDLE;
                    else if (drise) begin n_st = FAULT; m_err = ERR_SPURIOUS; end
                    else if (f) n_st = FIRE;
                end
                FIRE: begin
                    if (ab) n_st = IDLE;
                    else if (m_el == T_START) n_st = RUN;
                end
                RUN: begin
                    if (ab) n_st = IDLE;
                    else if (fall) begin n_st = COOLDOWN; m_cnt = m_cnt + 16'd1; end
                    else if (m_el == T_RUN) begin n_st = FAULT; m_err = ERR_TIMEOUT; end
                end
                COOLDOWN: begin
                    if (m_el == T_COOL) n_st = IDLE;
                end
                default: begin
                    if (ab) begin n_st = IDLE; m_err = ERR_NONE; end
                end
            endcase
            m_el = (n_st == m_st) ? m_el + 1 : 1;
            m_st = n_st;
            m_op = output_trigger;
            m_dp = detonator_triggered;

            cyc();
            chk("rnd_state", state_o, m_st);
            chk("rnd_err", err_o, m_err);
            chk("rnd_count", shot_count, m_cnt);
            chk("rnd_sel", strategy_sel, m_sel);
            chk("rnd_par", par, m_par);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
